xbus_lsu_master: RTL and testbench

//  Initiator side of the xbus: turns single load/store requests from the CPU
//  LSU into xbus cycles (cs/we/be/addr/wdata) and returns aligned, sign- or

---
 rtl/xbus_lsu_master.sv | 182 ++++++++++++++++++
 tb/tb_xbus_lsu_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_lsu_master.sv
// xbus_lsu_master: turns single LSU load/store requests into xbus cycles and
// returns aligned, sign- or zero-extended load data. One access in flight.
// Optional feature: define XBUS_MISALIGN_EXC_EN to reject misaligned half/word
// accesses with resp_err instead of issuing a bus cycle.
module xbus_lsu_master #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_xbus_cs,
    output logic        o_xbus_we,
    output logic [3:0]  o_xbus_be,
    output logic [31:0] o_xbus_addr,
    output logic [31:0] o_xbus_wdata,
    input  logic [31:0] i_xbus_rdata
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic        r_cs;
    logic        r_xwe;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

`ifdef XBUS_MISALIGN_EXC_EN
    logic r_err;

    assign w_misalign = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                        (i_req_size[1] && (i_req_addr[1:0] != 2'b00));
    assign o_resp_err = r_err && (r_state == StResp);

    // Remember whether the accepted request was rejected as misaligned
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_req_valid && (r_state == StIdle)) begin
            r_err <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
    assign o_resp_err = 1'b0;
`endif

    assign o_req_ready  = (r_state == StIdle);
    assign o_resp_valid = (r_state == StResp);
    assign o_resp_rdata = r_rdata;
    assign o_xbus_cs    = r_cs;
    assign o_xbus_we    = r_xwe;
    assign o_xbus_be    = r_be;
    assign o_xbus_addr  = r_addr;
    assign o_xbus_wdata = r_wdata;

    // Byte-lane enables and lane-replicated store data for the incoming request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_req_wdata;
        unique case (i_req_size)
            2'b00: begin
                w_be    = 4'b0001 << i_req_addr[1:0];
                w_wdata = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {i_req_addr[1], 1'b0};
                w_wdata = {2{i_req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_req_wdata;
            end
        endcase
    end

    assign w_byte = i_xbus_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = i_xbus_rdata[{r_lane[1], 4'b0000} +: 16];

    // Extract the addressed byte/half from the read word and extend it
    always_comb begin
        w_load_data = i_xbus_rdata;
        unique case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = i_xbus_rdata;
        endcase
    end

    // Access sequencer: latch request, drive one bus cycle, wait RD_LAT, respond
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_cs       <= 1'b0;
            r_xwe      <= 1'b0;
            r_be       <= 4'b0000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_we       <= i_req_we;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_lane     <= i_req_addr[1:0];
                        if (w_misalign) begin
                            // Rejected: no bus cycle, respond immediately
                            r_state <= StResp;
                            r_rdata <= 32'h0;
                        end else begin
                            r_state <= StAccess;
                            r_cs    <= 1'b1;
                            r_xwe   <= i_req_we;
                            r_be    <= w_be;
                            r_addr  <= {i_req_addr[31:2], 2'b00};
                            r_wdata <= w_wdata;
                        end
                    end
                end
                StAccess: begin
                    r_cs  <= 1'b0;
                    r_xwe <= 1'b0;
                    r_be  <= 4'b0000;
                    if (r_we) begin
                        r_state <= StResp;
                        r_rdata <= 32'h0;
                    end else begin
                        r_state <= StWait;
                        r_cnt   <= 3'(RD_LAT - 1);
                    end
                end
                StWait: begin
                    if (r_cnt == 3'd0) begin
                        r_rdata <= w_load_data;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_lsu_master.sv
// Self-checking bench for xbus_lsu_master with a RAM-type responder and a
// byte-array reference model of memory and LSU semantics.
module tb_xbus_lsu_master;

    localparam int unsigned RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        xbus_cs;
    logic        xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr;
    logic [31:0] xbus_wdata;
    logic [31:0] xbus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xbus_lsu_master #(.RD_LAT(RD_LAT)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .o_resp_rdata   (resp_rdata),
        .o_resp_err     (resp_err),
        .o_xbus_cs      (xbus_cs),
        .o_xbus_we      (xbus_we),
        .o_xbus_be      (xbus_be),
        .o_xbus_addr    (xbus_addr),
        .o_xbus_wdata   (xbus_wdata),
        .i_xbus_rdata   (xbus_rdata)
    );

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    // RAM responder: 128 words aliased over addr[8:2], read latency RD_LAT
    logic        ram_init;
    logic [31:0] ram     [0:127];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    assign xbus_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
        end else if (xbus_cs && xbus_we) begin
            for (int b = 0; b < 4; b++)
                if (xbus_be[b]) ram[xbus_addr[8:2]][8*b +: 8] <= xbus_wdata[8*b +: 8];
        end
        rd_pipe[0] <= (xbus_cs && !xbus_we) ? ram[xbus_addr[8:2]] : 32'hA5A5_5A5A;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference memory, byte granular, same 512-byte aliasing as the responder
    logic [7:0] ref_mem [0:511];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        return a - (a % 32'(n));
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (a % 32'(nbytes(sz))) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be = 4'b0000;
        int lo = int'(eff_addr(sz, a) % 4);
        for (int i = 0; i < nbytes(sz); i++) be[lo + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w = 32'h0;
        int n = nbytes(sz);
        for (int l = 0; l < 4; l++) w[8*l +: 8] = d[8*(l % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a);
        logic [31:0] v = 32'h0;
        logic [31:0] ea = eff_addr(sz, a);
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(ea + 32'(i)) % 512];
        if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ea = eff_addr(sz, a);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[(ea + 32'(i)) % 512] = d[8*i +: 8];
    endtask

    // One request through the DUT, checking bus cycle, latency and response
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        logic        mis;
        logic        found;
        logic [31:0] exp_rd;
        int          exp_lat;
`ifdef XBUS_MISALIGN_EXC_EN
        mis = misaligned(sz, a);
`else
        mis = 1'b0;
`endif
        exp_rd  = (mis || we) ? 32'h0 : model_load(sz, uns, a);
        exp_lat = mis ? 1 : (we ? 2 : 2 + int'(RD_LAT));
        rd      = 32'h0;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        check("ready_idle", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!mis) begin
            check("cs_access", xbus_cs, 1'b1);
            check("we_access", xbus_we, we);
            check("be_access", xbus_be, exp_be(sz, a));
            check("addr_access", xbus_addr, {a[31:2], 2'b00});
            if (we) check("wdata_access", xbus_wdata, exp_wdata(sz, d));
        end
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0 || mis) check("cs_idle", xbus_cs, 1'b0);
            if (resp_valid) begin
                check("latency", k + 1, exp_lat);
                check("resp_rdata", resp_rdata, exp_rd);
                check("resp_err", resp_err, mis);
                rd    = resp_rdata;
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!found) check("resp_timeout", 32'd0, 32'd1);
        if (we && !mis) model_store(sz, a, d);
        @(posedge clk); #1;
        check("resp_pulse", resp_valid, 1'b0);
        check("ready_after", req_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] w;
        int first, second, pulses;
        logic r;
        logic seen;

        rst = 1'b1; ram_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 128; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_cs", xbus_cs, 1'b0);
        check("rst_we", xbus_we, 1'b0);
        check("rst_be", xbus_be, 4'b0000);
        check("rst_addr", xbus_addr, 32'h0);
        check("rst_wdata", xbus_wdata, 32'h0);
        rst = 1'b0; ram_init = 1'b0;

        // Directed cases
        txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, rd);
        txn(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_005A, rd);
        txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd);
        check("lw_const", rd, 32'h5AAD_BEEF);
        txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_8056, rd);
        txn(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, rd);
        check("lb_const", rd, 32'hFFFF_FF80);
        txn(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, rd);
        check("lbu_const", rd, 32'h0000_0080);
        txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h8000_1234, rd);
        txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, rd);
        check("lh_const", rd, 32'hFFFF_8000);
        txn(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, rd);
        txn(1'b0, 2'b11, 1'b1, 32'h106, 32'h0, rd);

        // req_valid held high: second accept only after the response
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        req_valid = 1'b1;
        first = -1; second = -1; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            r = req_ready;
            if (resp_valid) pulses++;
            @(posedge clk);
            if (r) begin
                if (first < 0) first = c;
                else begin
                    second = c;
                    break;
                end
            end
            @(negedge clk);
        end
        #1 req_valid = 1'b0;
        check("hold_gap", 32'(second - first), 32'(RD_LAT + 3));
        check("hold_pulses", 32'(pulses), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            seen = resp_valid;
        end
        check("hold_drain", seen, 1'b1);
        @(posedge clk); #1;

        // Reset during WAIT discards the pending load
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h80; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_cs", xbus_cs, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        check("midrst_resp", resp_valid, 1'b0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("midrst_no_resp", seen, 1'b0);

        // Randomized traffic against the reference model
        for (int t = 0; t < 200; t++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
